sobel_frame_ctrl: RTL
=====================

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, input-memory address width.
REQ-003 SHALL have parameter PIXEL_COUNT, default 4096, input pixels per frame.
REQ-004 SHALL have parameter OUT_PIXEL_COUNT, default 3844, expected engine writes per frame, equal to (cols-2)*(rows-2).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1048576, maximum RUN duration.
REQ-006 SHALL have the following ports:
- clk_i  in  1  clock; single clock domain; all logic on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- host_start_i  in  1  request a new frame; sampled only in IDLE.
- host_wr_valid_i  in  1  host pixel beat valid.
- host_wr_data_i  in  DATA_WIDTH  host pixel data.
- host_wr_ready_o  out  1  host pixel beat accepted.
- host_ack_i  in  1  acknowledge done/error.
- imem_we_o  out  1  input-memory write enable.
- imem_addr_o  out  ADDR_WIDTH  input-memory address; shared port.
- imem_wdata_o  out  DATA_WIDTH  input-memory write data.
- eng_start_o  out  1  start level to the edge engine.
- eng_addr_i  in  ADDR_WIDTH  engine read address.
- eng_wr_en_i  in  1  engine output-write strobe.
- eng_finish_i  in  1  engine finish strobe.
- busy_o  out  1  high in every state except IDLE, DONE and ERROR.
- done_o  out  1  frame completed correctly.
- err_o  out  1  frame failed.
- out_cnt_o  out  ADDR_WIDTH  engine writes counted in the current frame.
- frame_cnt_o  out  16  frames completed without error.

Function
REQ-007 SHALL implement states IDLE, LOAD, KICK, RUN, DONE, ERROR, one-hot or binary.
REQ-008 IDLE: on host_start_i=1, SHALL clear load_cnt, out_cnt_o and the timeout counter, then go to LOAD; otherwise stay.
REQ-009 LOAD: host_wr_ready_o SHALL be 1; a beat is accepted when valid and ready are both 1.
REQ-010 On each accepted beat, SHALL drive combinationally in the same cycle: imem_we_o=1, imem_addr_o=load_cnt, imem_wdata_o=host_wr_data_i; load_cnt increments by 1.
REQ-011 On the beat that makes load_cnt equal PIXEL_COUNT, SHALL go to KICK; host_wr_ready_o SHALL be 0 from the next cycle.
REQ-012 Host beats outside LOAD SHALL be ignored; host_wr_ready_o=0 and nothing is written.
REQ-013 eng_start_o SHALL be a registered output, 1 only for the single cycle in KICK; KICK SHALL go to RUN unconditionally.
REQ-014 eng_start_o SHALL be 0 in every other state, so each frame presents exactly one rising edge.
REQ-015 RUN: imem_addr_o SHALL equal eng_addr_i combinationally, with imem_we_o=0.
REQ-016 In every state except LOAD, imem_addr_o SHALL be eng_addr_i and imem_wdata_o SHALL be 0.
REQ-017 RUN: out_cnt_o SHALL increment on each cycle with eng_wr_en_i=1, saturating at 2^ADDR_WIDTH-1.
REQ-018 RUN: the timeout counter SHALL increment every cycle.
REQ-019 RUN exit on eng_finish_i=1: if the count including any same-cycle eng_wr_en_i equals OUT_PIXEL_COUNT, SHALL go to DONE; else ERROR.
REQ-020 RUN exit on timeout: when the counter reaches TIMEOUT_CYCLES-1 without finish, SHALL go to ERROR; finish in that same cycle takes priority.
REQ-021 eng_wr_en_i and eng_finish_i SHALL be ignored outside RUN.
REQ-022 DONE: done_o=1 until host_ack_i=1; then frame_cnt_o increments (wrapping at 2^16) and the state goes to IDLE.
REQ-023 ERROR: err_o=1 until host_ack_i=1; then go to IDLE; frame_cnt_o unchanged.
REQ-024 host_start_i in the same cycle as host_ack_i SHALL be ignored; a new start is accepted only in IDLE.
REQ-025 out_cnt_o SHALL hold its value through DONE/ERROR until the next start.

Reset
REQ-026 On rst_i=1, at any time including mid-frame, SHALL force state IDLE immediately.
REQ-027 On reset, all counters, eng_start_o, imem_we_o, host_wr_ready_o, done_o, err_o, out_cnt_o and frame_cnt_o SHALL be 0.
REQ-028 Release of reset SHALL NOT generate eng_start_o.
REQ-029 Reset during LOAD or RUN SHALL abandon the frame; no partial status is reported.

Verification (PIXEL_COUNT=25, OUT_PIXEL_COUNT=9, TIMEOUT_CYCLES=64)
REQ-030 Start, then 25 back-to-back beats 0..24 -> imem writes addr 0..24 with matching data; eng_start_o high exactly one cycle after beat 24.
REQ-031 Engine model gives 9 eng_wr_en_i then eng_finish_i coincident with the 9th -> done_o=1, out_cnt_o=9; after ack frame_cnt_o=1 and IDLE.
REQ-032 Finish after only 8 writes -> err_o=1, frame_cnt_o unchanged; ack returns to IDLE.
REQ-033 No finish in RUN -> ERROR exactly 64 cycles after entering RUN.
REQ-034 host_wr_valid_i gapped randomly during LOAD and asserted in RUN -> only 25 writes occur; RUN beats not accepted.
REQ-035 rst_i asserted mid-RUN -> outputs 0 asynchronously; a following start runs a clean frame to done_o.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// Frame controller for a Sobel edge engine: loads a frame of host pixels into
// the input memory, kicks the engine, counts its output writes, and reports
// done or error back to the host.
module sobel_frame_ctrl #(
   parameter int DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 16,
   parameter int PIXEL_COUNT     = 4096,
   parameter int OUT_PIXEL_COUNT = 3844,
   parameter int TIMEOUT_CYCLES  = 1048576
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  host_start_i,
   input  logic                  host_wr_valid_i,
   input  logic [DATA_WIDTH-1:0] host_wr_data_i,
   output logic                  host_wr_ready_o,
   input  logic                  host_ack_i,
   output logic                  imem_we_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   output logic [DATA_WIDTH-1:0] imem_wdata_o,
   output logic                  eng_start_o,
   input  logic [ADDR_WIDTH-1:0] eng_addr_i,
   input  logic                  eng_wr_en_i,
   input  logic                  eng_finish_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [ADDR_WIDTH-1:0] out_cnt_o,
   output logic [15:0]           frame_cnt_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_KICK,
      S_RUN,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [ADDR_WIDTH-1:0] r_load_cnt;
   logic [ADDR_WIDTH-1:0] r_out_cnt;
   logic [TW-1:0]         r_tmo_cnt;
   logic [15:0]           r_frame_cnt;
   logic                  r_eng_start;

   logic                  w_beat;
   logic                  w_run_wr;
   logic [ADDR_WIDTH-1:0] w_out_inc;
   logic [ADDR_WIDTH-1:0] w_cnt_incl;

   // Output count saturates at all-ones instead of wrapping.
   assign w_out_inc = (&r_out_cnt) ? r_out_cnt : r_out_cnt + ADDR_WIDTH'(1);

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; finish decisions include a write strobe in the same cycle.
   always_comb begin
      w_next_state = r_state;
      w_beat       = 1'b0;
      w_run_wr     = 1'b0;
      w_cnt_incl   = r_out_cnt;
      case (r_state)
         S_IDLE: begin
            if (host_start_i) begin
               w_next_state = S_LOAD;
            end
         end
         S_LOAD: begin
            if (host_wr_valid_i) begin
               w_beat = 1'b1;
               if (r_load_cnt == ADDR_WIDTH'(PIXEL_COUNT - 1)) begin
                  w_next_state = S_KICK;
               end
            end
         end
         S_KICK: begin
            w_next_state = S_RUN;
         end
         S_RUN: begin
            w_run_wr = eng_wr_en_i;
            if (eng_wr_en_i) begin
               w_cnt_incl = w_out_inc;
            end
            if (eng_finish_i) begin
               w_next_state = (w_cnt_incl == ADDR_WIDTH'(OUT_PIXEL_COUNT)) ? S_DONE : S_ERROR;
            end else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               w_next_state = S_ERROR;
            end
         end
         S_DONE, S_ERROR: begin
            if (host_ack_i) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Counters and the registered engine start pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_load_cnt  <= '0;
         r_out_cnt   <= '0;
         r_tmo_cnt   <= '0;
         r_frame_cnt <= '0;
         r_eng_start <= 1'b0;
      end else begin
         r_eng_start <= (w_next_state == S_KICK);
         if (r_state == S_IDLE && host_start_i) begin
            r_load_cnt <= '0;
            r_out_cnt  <= '0;
            r_tmo_cnt  <= '0;
         end
         if (w_beat) begin
            r_load_cnt <= r_load_cnt + ADDR_WIDTH'(1);
         end
         if (r_state == S_RUN) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
            if (w_run_wr) begin
               r_out_cnt <= w_cnt_incl;
            end
         end
         if (r_state == S_DONE && host_ack_i) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign host_wr_ready_o = (r_state == S_LOAD);
   assign imem_we_o       = w_beat;
   assign imem_addr_o     = (r_state == S_LOAD) ? r_load_cnt : eng_addr_i;
   assign imem_wdata_o    = (r_state == S_LOAD) ? host_wr_data_i : '0;
   assign eng_start_o     = r_eng_start;
   assign busy_o          = (r_state == S_LOAD) || (r_state == S_KICK) || (r_state == S_RUN);
   assign done_o          = (r_state == S_DONE);
   assign err_o           = (r_state == S_ERROR);
   assign out_cnt_o       = r_out_cnt;
   assign frame_cnt_o     = r_frame_cnt;

endmodule
